// File: rtl/apb_rr_scheduler_if.sv
// APB bus bundle between the round-robin scheduler (master) and the
// externally muxed slave response path.
interface apb_rr_scheduler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic                  pwrite;
   logic [1:0]            psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output paddr, pwdata, pwrite, psel, penable,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwdata, pwrite, psel, penable,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_rr_scheduler.sv
// Two-requester round-robin APB master: grants one requester at a time,
// runs a SETUP/ACCESS transfer with a wait-state timeout and pulses done.
module apb_rr_scheduler #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic [1:0]              req,
   input  logic [1:0]              req_wr,
   input  logic [1:0]              req_slv,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              done,
   output logic                    err,
   output logic [DATA_WIDTH-1:0]   rdata,
   apb_rr_scheduler_if.master      apb
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;
   localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

   logic [1:0]            state_r;
   logic                  last_grant_r;
   logic                  gnt_r;
   logic [7:0]            cnt_r;
   logic [1:0]            psel_r;
   logic                  penable_r;
   logic                  pwrite_r;
   logic [ADDR_WIDTH-1:0] paddr_r;
   logic [DATA_WIDTH-1:0] pwdata_r;
   logic [1:0]            done_r;
   logic                  err_r;
   logic [DATA_WIDTH-1:0] rdata_r;

   logic                  gnt_s;
   logic                  timeout_s;

   function automatic logic [1:0] onehot2(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

   // Round-robin pick: the requester after last_grant wins, else the lone one.
   always_comb begin
      gnt_s = last_grant_r;
      if (req[~last_grant_r]) begin
         gnt_s = ~last_grant_r;
      end else begin
         gnt_s = last_grant_r;
      end
   end

   // Timeout fires only on the final allowed wait cycle with no pready.
   always_comb begin
      timeout_s = 1'b0;
      if ((cnt_r == TO_LAST) && !apb.pready) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Transfer FSM; the APB fields double as the latched request.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_r      <= ST_IDLE;
         last_grant_r <= 1'b1;
         gnt_r        <= 1'b0;
         cnt_r        <= 8'd0;
         psel_r       <= 2'b00;
         penable_r    <= 1'b0;
         pwrite_r     <= 1'b0;
         paddr_r      <= '0;
         pwdata_r     <= '0;
         done_r       <= 2'b00;
         err_r        <= 1'b0;
         rdata_r      <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r  <= 2'b00;
               err_r   <= 1'b0;
               rdata_r <= '0;
               if (req != 2'b00) begin
                  gnt_r        <= gnt_s;
                  last_grant_r <= gnt_s;
                  psel_r       <= onehot2(req_slv[gnt_s]);
                  pwrite_r     <= req_wr[gnt_s];
                  paddr_r      <= gnt_s ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                        : req_addr[ADDR_WIDTH-1:0];
                  pwdata_r     <= gnt_s ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : req_wdata[DATA_WIDTH-1:0];
                  state_r      <= ST_SETUP;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SETUP: begin
               penable_r <= 1'b1;
               cnt_r     <= 8'd0;
               state_r   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apb.pready) begin
                  psel_r    <= 2'b00;
                  penable_r <= 1'b0;
                  done_r    <= onehot2(gnt_r);
                  err_r     <= apb.pslverr;
                  rdata_r   <= pwrite_r ? '0 : apb.prdata;
                  state_r   <= ST_RESP;
               end else if (timeout_s) begin
                  psel_r    <= 2'b00;
                  penable_r <= 1'b0;
                  done_r    <= onehot2(gnt_r);
                  err_r     <= 1'b1;
                  rdata_r   <= '0;
                  state_r   <= ST_RESP;
               end else begin
                  cnt_r   <= cnt_r + 8'd1;
                  state_r <= ST_ACCESS;
               end
            end
            ST_RESP: begin
               done_r  <= 2'b00;
               err_r   <= 1'b0;
               rdata_r <= '0;
               state_r <= ST_IDLE;
            end
            default: begin
               psel_r    <= 2'b00;
               penable_r <= 1'b0;
               done_r    <= 2'b00;
               err_r     <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign apb.psel    = psel_r;
   assign apb.penable = penable_r;
   assign apb.pwrite  = pwrite_r;
   assign apb.paddr   = paddr_r;
   assign apb.pwdata  = pwdata_r;
   assign done        = done_r;
   assign err         = err_r;
   assign rdata       = rdata_r;

endmodule
